// File: rtl/fir_pkg.sv
// Shared constants, sample types and the 16-bit saturation helpers used by the
// FIR core and its downstream decimator.
package fir_pkg;

  localparam int unsigned IN_WIDTH  = 32;  // FIR accumulator width (signed)
  localparam int unsigned OUT_WIDTH = 16;  // rescaled sample width
  localparam int unsigned SHIFT     = 15;  // Q15 coefficient scaling
  localparam int unsigned DECIM_W   = 8;   // decimation factor width
  localparam int unsigned M_WIDTH   = 32;  // m_axis tdata width
  localparam int unsigned STRB_W    = M_WIDTH / 8;

  // One guard bit so the rounding add cannot wrap.
  localparam int unsigned SUM_W     = IN_WIDTH + 1;
  // Width of the accumulator after the right shift (before saturation).
  localparam int unsigned SCALED_W  = SUM_W - SHIFT;

  typedef logic signed [15:0] sample_t;

  // Payload carried through the output skid buffer.
  typedef struct packed {
    logic    last;
    sample_t data;
  } out_beat_t;

  // Value fits in 16 bits iff every bit from the sample sign bit upward agrees.
  function automatic logic is_sat16(input logic [SCALED_W-1:0] y);
    logic [SCALED_W-OUT_WIDTH:0] top;
    top = y[SCALED_W-1:OUT_WIDTH-1];
    return !((&top) || (~|top));
  endfunction

  // Clamp a shifted accumulator to the signed 16-bit range.
  function automatic sample_t sat16(input logic [SCALED_W-1:0] y);
    if (is_sat16(y)) begin
      return y[SCALED_W-1] ? 16'sh8000 : 16'sh7FFF;
    end
    return sample_t'(y[OUT_WIDTH-1:0]);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered AXI-Stream buffer: an output register plus one skid
// entry, so in_ready is a flop and the path still runs at full throughput.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_data/in_valid    upstream payload and valid
//   in_ready            registered; low only while both entries are occupied
//   out_data/out_valid  registered output beat, held while out_ready is low
//   out_ready           downstream ready
//   empty_c             both entries free (combinational from state)
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             empty_c
);

  logic [WIDTH-1:0] out_q,  out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q,  out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q,      ready_d;
  logic             in_fire;

  // Next-state: the skid entry always drains first to preserve ordering.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    in_fire      = in_valid && ready_q;

    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        // ready_q is low whenever skid is occupied, so no input can arrive here.
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_d = in_data;
        end
      end
    end else if (in_fire) begin
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end

    ready_d = !skid_valid_d;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign empty_c   = !out_valid_q && !skid_valid_q;

endmodule

// File: rtl/fir_axis_decimator.sv
// Rescales the 32-bit FIR accumulator stream to saturated 16-bit samples and
// keeps 1 of every D beats (plus every tlast beat) on an AXI-Stream master.
// Optional build macro: ROUND_EN -- round-half-up before the shift instead of
// plain floor truncation.
// Ports:
//   axis_aclk, axis_aresetn     clock, synchronous active-low reset
//   decim_factor                D (0 behaves as 1), latched between frames when idle
//   s_axis_tdata/tvalid/tlast   FIR output stream in
//   s_axis_tready               registered, low only when the output buffer is full
//   m_axis_tdata/tstrb/tvalid/tlast/tready   decimated, sign-extended stream out
//   sat_flag                    sticky, set when any accepted sample saturates
module fir_axis_decimator
  import fir_pkg::*;
(
  input  logic                axis_aclk,
  input  logic                axis_aresetn,
  input  logic [DECIM_W-1:0]  decim_factor,
  input  logic [IN_WIDTH-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [M_WIDTH-1:0]  m_axis_tdata,
  output logic [STRB_W-1:0]   m_axis_tstrb,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                sat_flag
);

  localparam int unsigned BEAT_W = $bits(out_beat_t);

  logic [SUM_W-1:0]    acc_ext;
  logic [SUM_W-1:0]    sum;
  logic [SCALED_W-1:0] scaled;
  sample_t             sample;
  logic                sample_sat;

  logic [DECIM_W-1:0]  phase_q, phase_d;
  logic [DECIM_W-1:0]  d_q,     d_d;
  logic                sat_q,   sat_d;
  logic                accept;
  logic                keep;
  logic                buf_empty;

  out_beat_t           in_beat;
  out_beat_t           out_beat;
  logic [BEAT_W-1:0]   out_bits;

  // Scaler: the upper bits of the (optionally rounded) sum are the floor shift.
  assign acc_ext = {s_axis_tdata[IN_WIDTH-1], s_axis_tdata};
`ifdef ROUND_EN
  assign sum = acc_ext + (SUM_W'(1) << (SHIFT - 1));
`else
  assign sum = acc_ext;
`endif
  assign scaled     = sum[SUM_W-1:SHIFT];
  assign sample     = sat16(scaled);
  assign sample_sat = is_sat16(scaled);

  assign accept = s_axis_tvalid && s_axis_tready;
  assign keep   = (phase_q == '0) || s_axis_tlast;

  // Phase counter, frame-boundary D latch and sticky saturation flag.
  always_comb begin
    phase_d = phase_q;
    d_d     = d_q;
    sat_d   = sat_q;
    if (accept) begin
      if (s_axis_tlast || (phase_q == d_q - DECIM_W'(1))) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + DECIM_W'(1);
      end
      if (sample_sat) begin
        sat_d = 1'b1;
      end
    end
    if ((phase_q == '0) && buf_empty) begin
      d_d = (decim_factor == '0) ? DECIM_W'(1) : decim_factor;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      phase_q <= '0;
      d_q     <= DECIM_W'(1);
      sat_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      d_q     <= d_d;
      sat_q   <= sat_d;
    end
  end

  // Dropped beats never enter the buffer; tready still comes only from the buffer.
  assign in_beat.last = s_axis_tlast;
  assign in_beat.data = sample;

  axis_skid_buffer #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk       (axis_aclk),
    .rst_n     (axis_aresetn),
    .in_data   (in_beat),
    .in_valid  (s_axis_tvalid && keep),
    .in_ready  (s_axis_tready),
    .out_data  (out_bits),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .empty_c   (buf_empty)
  );

  assign out_beat     = out_beat_t'(out_bits);
  assign m_axis_tdata = {{(M_WIDTH-OUT_WIDTH){out_beat.data[OUT_WIDTH-1]}}, out_beat.data};
  assign m_axis_tlast = out_beat.last;
  assign m_axis_tstrb = {STRB_W{m_axis_tvalid}};
  assign sat_flag     = sat_q;

endmodule

// File: tb/tb_fir_axis_decimator.sv
// Directed bench for fir_axis_decimator: scaling, saturation, rounding mode,
// decimation with tlast, backpressure and mid-frame reset.
module tb_fir_axis_decimator;

  logic        axis_aclk;
  logic        axis_aresetn;
  logic [7:0]  decim_factor;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        sat_flag;

  int vectors;
  int miscompares;

  logic [31:0] got_d[$];
  logic        got_l[$];
  logic [31:0] exp_q[$];

  fir_axis_decimator dut (
    .axis_aclk     (axis_aclk),
    .axis_aresetn  (axis_aresetn),
    .decim_factor  (decim_factor),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .sat_flag      (sat_flag)
  );

  initial axis_aclk = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  // Record every completed output transfer.
  always @(posedge axis_aclk) begin
    if (axis_aresetn && m_axis_tvalid && m_axis_tready) begin
      got_d.push_back(m_axis_tdata);
      got_l.push_back(m_axis_tlast);
    end
  end

  task automatic tick();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Compare captured output transfers against exp_q; last_idx marks the tlast beat.
  task automatic check_out(input string tag, input int last_idx);
    check($sformatf("%s_count", tag), 32'(got_d.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_d[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), (i == last_idx) ? 32'd1 : 32'd0);
    end
    got_d.delete();
    got_l.delete();
  endtask

  // Stream beats (start+i)<<15 honouring s_axis_tready; bp toggles m_axis_tready 1,0,0,1.
  task automatic push_frame(input int n, input int start, input bit with_last, input bit bp);
    int          i;
    int          cyc;
    logic        stall;
    logic        accepted;
    logic [31:0] held;
    i   = 0;
    cyc = 0;
    while (i < n && cyc < 200) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'(start + i) << 15;
      s_axis_tlast  = with_last && (i == n - 1);
      if (bp) m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      stall    = m_axis_tvalid && !m_axis_tready;
      held     = m_axis_tdata;
      accepted = s_axis_tready;
      tick();
      if (bp && stall) begin
        check("stall_valid", 32'(m_axis_tvalid), 32'd1);
        check("stall_data", m_axis_tdata, held);
      end
      if (bp && !s_axis_tready) check("ready_low_needs_out", 32'(m_axis_tvalid), 32'd1);
      if (accepted) i++;
      cyc++;
    end
    check("frame_accepted", 32'(i), 32'(n));
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  task automatic send_one(input logic [31:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = 1'b0;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    m_axis_tready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    axis_aresetn  = 1'b0;
    decim_factor  = 8'd1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_s_ready", 32'(s_axis_tready), 32'd0);
    check("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_data", m_axis_tdata, 32'd0);
    check("rst_m_last", 32'(m_axis_tlast), 32'd0);
    check("rst_strb", 32'(m_axis_tstrb), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    axis_aresetn = 1'b1;
    tick();
    check("rel_s_ready", 32'(s_axis_tready), 32'd1);
    tick();

    // 1: D=1, 0x8000 x4 -> 1 per cycle with latency 1
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h0000_8000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t1_valid%0d", k), 32'(m_axis_tvalid), 32'd1);
      check($sformatf("t1_data%0d", k), m_axis_tdata, 32'd1);
    end
    check("t1_strb", 32'(m_axis_tstrb), 32'hF);
    s_axis_tvalid = 1'b0;
    tick();
    check("t1_idle", 32'(m_axis_tvalid), 32'd0);
    exp_q = '{32'd1, 32'd1, 32'd1, 32'd1};
    check_out("t1", -1);

    // 2: D=4 ramp 0..15 with tlast on 15
    decim_factor = 8'd4;
    repeat (2) tick();
    push_frame(16, 0, 1'b1, 1'b0);
    drain();
    exp_q = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd15};
    check_out("t2", 4);
    check("t2_sat", 32'(sat_flag), 32'd0);

    // 3: saturation, flag sticky
    decim_factor = 8'd1;
    repeat (2) tick();
    send_one(32'h7FFF_FFFF);
    send_one(32'h8000_0000);
    drain();
    exp_q = '{32'h0000_7FFF, 32'hFFFF_8000};
    check_out("t3", -1);
    check("t3_sat", 32'(sat_flag), 32'd1);
    send_one(32'h0000_8000);
    drain();
    exp_q = '{32'd1};
    check_out("t3b", -1);
    check("t3_sat_sticky", 32'(sat_flag), 32'd1);

    // 4: rounding vs truncation at the half-LSB point
    send_one(32'h0000_4000);
    send_one(32'hFFFF_C000);
    drain();
`ifdef ROUND_EN
    exp_q = '{32'h0000_0001, 32'h0000_0000};
`else
    exp_q = '{32'h0000_0000, 32'hFFFF_FFFF};
`endif
    check_out("t4", -1);

    // 5: D=2 under 1-0-0-1 backpressure, ramp 0..7 with tlast on 7
    decim_factor = 8'd2;
    repeat (2) tick();
    push_frame(8, 0, 1'b1, 1'b1);
    drain();
    exp_q = '{32'd0, 32'd2, 32'd4, 32'd6, 32'd7};
    check_out("t5", 4);

    // 5b: ready drops exactly when output and skid entries are both occupied
    decim_factor = 8'd1;
    repeat (3) tick();
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'd20 << 15;
    tick();
    check("t5b_ready1", 32'(s_axis_tready), 32'd1);
    check("t5b_data1", m_axis_tdata, 32'd20);
    s_axis_tdata = 32'd21 << 15;
    tick();
    check("t5b_ready2", 32'(s_axis_tready), 32'd0);
    check("t5b_data2", m_axis_tdata, 32'd20);
    s_axis_tdata = 32'd22 << 15;
    tick();
    check("t5b_ready3", 32'(s_axis_tready), 32'd0);
    check("t5b_data3", m_axis_tdata, 32'd20);
    m_axis_tready = 1'b1;
    tick();
    check("t5b_data4", m_axis_tdata, 32'd21);
    check("t5b_ready4", 32'(s_axis_tready), 32'd1);
    tick();
    check("t5b_data5", m_axis_tdata, 32'd22);
    s_axis_tvalid = 1'b0;
    drain();
    exp_q = '{32'd20, 32'd21, 32'd22};
    check_out("t5b", -1);

    // 6: reset after 3 beats of a D=4 frame, next frame restarts at phase 0
    decim_factor = 8'd4;
    repeat (3) tick();
    m_axis_tready = 1'b0;
    push_frame(3, 1, 1'b0, 1'b0);
    m_axis_tready = 1'b0;
    check("t6_pre_valid", 32'(m_axis_tvalid), 32'd1);
    axis_aresetn = 1'b0;
    tick();
    check("t6_rst_valid", 32'(m_axis_tvalid), 32'd0);
    check("t6_rst_ready", 32'(s_axis_tready), 32'd0);
    axis_aresetn  = 1'b1;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    got_d.delete();
    got_l.delete();
    push_frame(5, 10, 1'b1, 1'b0);
    drain();
    exp_q = '{32'd10, 32'd14};
    check_out("t6", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
